// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters.
// Define MULT_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles (err reported).
module mult_arbiter #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] result,
  output logic        err,
  output logic        busy,
  output logic        m_start,
  output logic [7:0]  m_a,
  output logic [7:0]  m_b,
  input  logic [15:0] m_product,
  input  logic        m_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t      state;
  state_t      state_nxt;
  logic        gnt;
  logic        gnt_nxt;
  logic        pick;
  logic        tmo;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] res_q;

  // gnt is both the current grant and the last-served requester
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    pick      = (req0 & req1) ? ~gnt : req1;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt = ISSUE;
          gnt_nxt   = pick;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (m_done | tmo) begin
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
    end else if (state == IDLE && (req0 | req1)) begin
      a_q <= pick ? a1 : a0;
      b_q <= pick ? b1 : b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= 16'h0000;
    end else if (state == WAIT) begin
      if (m_done) begin
        res_q <= m_product;
      end else if (tmo) begin
        res_q <= 16'h0000;
      end
    end
  end

`ifdef MULT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  assign tmo = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // m_done wins over a timeout landing on the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state == WAIT) begin
      err_q <= ~m_done & tmo;
    end
  end

  assign err = err_q & (state == RESP);
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign m_start = (state == ISSUE);
  assign busy    = (state != IDLE);
  assign ack0    = (state == RESP) & ~gnt;
  assign ack1    = (state == RESP) & gnt;
  assign m_a     = a_q;
  assign m_b     = b_q;
  assign result  = res_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed steps plus randomized
// traffic against a round-robin / signed-product reference model.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ack0, ack1;
  logic [15:0] result;
  logic        err, busy, m_start;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_product;
  logic        m_done;

  int checks = 0;
  int errors = 0;
  int last_srv = 1;
  logic [15:0] last_res = 16'h0000;

  mult_arbiter #(.TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .result(result), .err(err), .busy(busy),
    .m_start(m_start), .m_a(m_a), .m_b(m_b),
    .m_product(m_product), .m_done(m_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a,
                                       input logic [7:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return 16'(x * y);
  endfunction

  function automatic int winner(input logic r0, input logic r1);
    if (r0 && r1) return (last_srv == 1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  // mode 0: drop req after ack, 1: keep req, 2: drop req at m_start
  task automatic serve(input int who, input int dly, input bit use_p,
                       input logic [15:0] p, input int mode);
    int n;
    logic [7:0] ea, eb;
    logic [15:0] er;
    n = 0;
    ea = (who == 1) ? a1 : a0;
    eb = (who == 1) ? b1 : b0;
    er = use_p ? p : prod(ea, eb);
    while (m_start !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk("m_start_seen", 16'(m_start), 16'h1);
    chk("m_a", 16'(m_a), 16'(ea));
    chk("m_b", 16'(m_b), 16'(eb));
    if (mode == 2) begin
      if (who == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    step();
    chk("m_start_pulse", 16'(m_start), 16'h0);
    for (int i = 1; i < dly; i++) begin
      chk("wait_busy", 16'(busy), 16'h1);
      chk("m_a_hold", 16'(m_a), 16'(ea));
      chk("m_b_hold", 16'(m_b), 16'(eb));
      step();
    end
    m_product = er;
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    m_product = 16'($urandom);
    chk("ack0", 16'(ack0), 16'(who == 0));
    chk("ack1", 16'(ack1), 16'(who == 1));
    chk("result", result, er);
    chk("err_clear", 16'(err), 16'h0);
    last_srv = who;
    last_res = er;
    if (mode == 0) begin
      if (who == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    step();
    chk("ack_one_cycle", 16'(ack0 | ack1), 16'h0);
    chk("result_hold", result, er);
  endtask

  initial begin
    int w, n, prev;
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    m_done = 1'b0; m_product = 16'h0000;
    step();
    step();
    chk("rst_ack0", 16'(ack0), 16'h0);
    chk("rst_ack1", 16'(ack1), 16'h0);
    chk("rst_start", 16'(m_start), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_result", result, 16'h0);
    chk("rst_m_a", 16'(m_a), 16'h0);
    chk("rst_m_b", 16'(m_b), 16'h0);
    rst = 1'b1;
    step();

    // single request, minimum latency
    a0 = 8'd3; b0 = 8'hFB; req0 = 1'b1;
    step();
    chk("lat_issue", 16'(m_start), 16'h1);
    chk("lat_m_a", 16'(m_a), 16'h0003);
    chk("lat_m_b", 16'(m_b), 16'h00FB);
    chk("lat_busy", 16'(busy), 16'h1);
    step();
    chk("lat_start_low", 16'(m_start), 16'h0);
    m_product = 16'hFFF1; m_done = 1'b1;
    step();
    m_done = 1'b0;
    chk("lat_ack0", 16'(ack0), 16'h1);
    chk("lat_ack1", 16'(ack1), 16'h0);
    chk("lat_result", result, 16'hFFF1);
    chk("lat_err", 16'(err), 16'h0);
    req0 = 1'b0; last_srv = 0; last_res = 16'hFFF1;
    step();
    chk("lat_idle_ack", 16'(ack0), 16'h0);
    chk("lat_idle_busy", 16'(busy), 16'h0);
    chk("lat_hold", result, 16'hFFF1);

    // simultaneous requests after reset
    rst = 1'b0; step(); rst = 1'b1; last_srv = 1; last_res = 16'h0;
    step();
    a0 = 8'($urandom); b0 = 8'($urandom);
    a1 = 8'($urandom); b1 = 8'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    w = winner(req0, req1);
    serve(w, 1, 1'b0, 16'h0, 0);
    w = winner(req0, req1);
    serve(w, 2, 1'b0, 16'h0, 0);
    step();
    chk("tie_idle", 16'(busy), 16'h0);

    // both held: strict alternation
    req0 = 1'b1; req1 = 1'b1; prev = -1;
    for (int k = 0; k < 6; k++) begin
      w = winner(req0, req1);
      serve(w, 1 + k % 3, 1'b0, 16'h0, 1);
      prev = w;
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("alt_idle", 16'(busy), 16'h0);

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1;
      end
      if (!req0 && !req1) begin
        a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
      end
      w = winner(req0, req1);
      serve(w, $urandom_range(1, 4), 1'b0, 16'h0,
            ($urandom_range(0, 1) == 1) ? 0 : 2);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    chk("rand_idle", 16'(busy), 16'h0);

    // reset during WAIT
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    n = 0;
    while (m_start !== 1'b1 && n < 16) begin step(); n++; end
    chk("rw_start", 16'(m_start), 16'h1);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("rw_busy", 16'(busy), 16'h0);
    chk("rw_start0", 16'(m_start), 16'h0);
    chk("rw_acks", 16'(ack0 | ack1), 16'h0);
    chk("rw_err", 16'(err), 16'h0);
    chk("rw_result", result, 16'h0);
    chk("rw_m_a", 16'(m_a), 16'h0);
    chk("rw_m_b", 16'(m_b), 16'h0);
    req0 = 1'b0;
    step();
    rst = 1'b1; last_srv = 1; last_res = 16'h0;
    m_product = 16'h7777; m_done = 1'b1;
    step();
    m_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rw_no_ack", 16'(ack0 | ack1), 16'h0);
      chk("rw_no_start", 16'(m_start), 16'h0);
      chk("rw_quiet", 16'(busy), 16'h0);
      chk("rw_res0", result, 16'h0);
      step();
    end
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    w = winner(req0, req1);
    serve(w, 1, 1'b0, 16'h0, 0);

    // stray m_done in IDLE, then extreme operands
    m_product = 16'h1234; m_done = 1'b1;
    step();
    m_done = 1'b0;
    chk("stray_busy", 16'(busy), 16'h0);
    chk("stray_ack", 16'(ack0 | ack1), 16'h0);
    chk("stray_result", result, last_res);
    a1 = 8'h80; b1 = 8'h80; req1 = 1'b1;
    w = winner(req0, req1);
    serve(w, 1, 1'b1, 16'h4000, 0);

`ifdef MULT_TIMEOUT_EN
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    n = 0;
    while (m_start !== 1'b1 && n < 16) begin step(); n++; end
    chk("to_start", 16'(m_start), 16'h1);
    step();
    for (int i = 0; i < 32; i++) begin
      chk("to_wait_ack", 16'(ack0 | ack1), 16'h0);
      chk("to_wait_busy", 16'(busy), 16'h1);
      step();
    end
    chk("to_ack0", 16'(ack0), 16'h1);
    chk("to_err", 16'(err), 16'h1);
    chk("to_result", result, 16'h0);
    req0 = 1'b0; last_srv = 0;
    step();
    chk("to_busy_drop", 16'(busy), 16'h0);
    chk("to_err_drop", 16'(err), 16'h0);
`else
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    n = 0;
    while (m_start !== 1'b1 && n < 16) begin step(); n++; end
    chk("nt_start", 16'(m_start), 16'h1);
    step();
    for (int i = 0; i < 40; i++) begin
      chk("nt_wait_ack", 16'(ack0 | ack1), 16'h0);
      chk("nt_wait_busy", 16'(busy), 16'h1);
      step();
    end
    m_product = prod(a0, b0); m_done = 1'b1;
    step();
    m_done = 1'b0;
    chk("nt_ack0", 16'(ack0), 16'h1);
    chk("nt_err", 16'(err), 16'h0);
    chk("nt_result", result, prod(a0, b0));
    req0 = 1'b0; last_srv = 0;
    step();
    chk("nt_idle", 16'(busy), 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 32, WAIT-state cycles before an operation is aborted (used only with MULT_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0, req1  input  1 each  request levels, held by requester until its ack.
REQ-005 SHALL have ports: a0, b0, a1, b1  input  8 each  signed two's-complement operands of requester 0/1.
REQ-006 SHALL have ports: ack0, ack1  output  1 each  one-cycle result-ready pulse to requester 0/1.
REQ-007 SHALL have port: result  output  16  signed product of the most recently served request.
REQ-008 SHALL have port: err  output  1  high together with an ack when that operation timed out.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have ports: m_start  output  1,  m_a  output  8,  m_b  output  8  command bus to the shared sequential multiplier.
REQ-011 SHALL have ports: m_product  input  16,  m_done  input  1  multiplier response.

Function
REQ-012 SHALL implement an FSM with states IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: if any req is high, SHALL latch the granted requester's operands into m_a/m_b and move to ISSUE next edge.
REQ-014 Arbitration SHALL be round-robin: single request wins; on a tie, the requester not served last wins; the last-served register updates at the IDLE->ISSUE transition.
REQ-015 ISSUE: m_start SHALL be high for exactly this one cycle; next state is WAIT unconditionally.
REQ-016 m_done SHALL be sampled only in WAIT; m_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-017 WAIT: on m_done high, SHALL register m_product into result and move to RESP.
REQ-018 RESP: SHALL pulse exactly one ack (that of the granted requester) for one cycle, then return to IDLE.
REQ-019 result SHALL hold its value until the next RESP; m_a/m_b SHALL stay stable from ISSUE through WAIT.
REQ-020 A req dropped mid-operation SHALL not abort it; the operation completes and its ack is still issued.
REQ-021 A req still high in the IDLE cycle following its ack SHALL be treated as a new request, subject to REQ-014.
REQ-022 Minimum request-to-ack latency SHALL be 4 cycles (IDLE, ISSUE, WAIT with m_done, RESP).

Reset
REQ-023 rst low SHALL immediately force state IDLE; ack0, ack1, m_start, busy and err to 0; result, m_a, m_b and the timeout counter to 0.
REQ-024 The last-served register SHALL reset to requester 1, so requester 0 wins the first tie.
REQ-025 Reset asserted mid-operation SHALL abandon that operation with no ack and no later m_start reissue.

Configuration
REQ-026 With macro MULT_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle; if TIMEOUT_CYC WAIT cycles elapse without m_done, the FSM SHALL enter RESP with result=0 and err=1 for the ack cycle.
REQ-027 Without MULT_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter SHALL be built and err SHALL be tied to 0.
REQ-028 In every other respect, behaviour SHALL be identical with and without the macro.

Verification
REQ-029 req0 only, a0=3, b0=-5, m_done asserted 1 cycle after m_start with m_product=16'hFFF1 -> m_a=3, m_b=8'hFB; ack0 pulses 4 cycles after req0; result=16'hFFF1.
REQ-030 req0 and req1 rise in the same cycle after reset -> requester 0 served first, then requester 1; two m_start pulses; ack0 precedes ack1.
REQ-031 req0 held continuously high, req1 held high -> acks alternate 0,1,0,1; no requester served twice in a row while the other is waiting.
REQ-032 MULT_TIMEOUT_EN defined, TIMEOUT_CYC=32, m_done held low -> after 32 WAIT cycles ack pulses with err=1, result=0; busy drops the following cycle.
REQ-033 rst pulsed low during WAIT -> all outputs 0 immediately; late m_done then ignored; no ack; next req restarts from ISSUE.
REQ-034 m_done pulsed while IDLE, then req1 with a1=-128, b1=-128, m_product=16'h4000 -> stray m_done ignored; ack1 with result=16'h4000.
